// File: rtl/pc_seq_defs.sv
// Shared encodings and sizing for the fetch-stage PC sequencer and its BTB.
package pc_seq_defs;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr_e;

  localparam int BTB_ENTRIES_DFLT = 16;
  localparam int BTB_IDX_W        = $clog2(BTB_ENTRIES_DFLT);
  localparam int BTB_TAG_W        = 30 - BTB_IDX_W;

  // Saturating 2-bit update of the global direction counter.
  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    logic [1:0] v;
    v = cur;
    if (taken) begin
      if (v != 2'b11) v = v + 2'd1;
      else            v = 2'b11;
    end else begin
      if (v != 2'b00) v = v - 2'd1;
      else            v = 2'b00;
    end
    return ctr_e'(v);
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational read port, one synchronous write port,
// valid bits cleared asynchronously by reset.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_target,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
    else       valid_d = valid_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: BTB + global 2-bit counter prediction, mispredict
// redirect, stall and halt handling; drives the PC register and pipeline flush.
module pc_sequencer
  import pc_seq_defs::*;
#(
  parameter int          BTB_ENTRIES = BTB_ENTRIES_DFLT,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc,
  input  logic        stall,
  input  logic        halt,
  input  logic        ex_valid,
  input  logic        ex_is_cond,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_actual_next_pc,
  input  logic [31:0] ex_pred_next_pc,
  output logic [31:0] next_pc,
  output logic        pc_write,
  output logic [31:0] fetch_pred_next_pc,
  output logic        flush
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  seq_state_e       state_q, state_d;
  ctr_e             ctr_q, ctr_d;
  logic             btb_valid;
  logic [TAG_W-1:0] btb_tag;
  logic [31:0]      btb_target;
  logic             btb_hit, mispredict, train_en, btb_we;
  logic [31:0]      pc_plus4;
  logic             unused_ex_pc_lo;

  branch_target_buffer #(
    .ENTRIES(BTB_ENTRIES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_btb (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (current_pc[IDX_W+1:2]),
    .rd_valid (btb_valid),
    .rd_tag   (btb_tag),
    .rd_target(btb_target),
    .wr_en    (btb_we),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_tag   (ex_pc[31:IDX_W+2]),
    .wr_target(ex_actual_next_pc)
  );

  assign unused_ex_pc_lo    = ^ex_pc[1:0];
  assign pc_plus4           = current_pc + 32'd4;
  assign btb_hit            = btb_valid && (btb_tag == current_pc[31:IDX_W+2]);
  assign fetch_pred_next_pc = (btb_hit && ctr_q[1]) ? btb_target : pc_plus4;
  assign mispredict         = ex_valid && (ex_actual_next_pc != ex_pred_next_pc);
  // halt comes from WB, which is older than EX, so it also suppresses training.
  assign train_en           = ex_valid && !halt && (state_q != HALTED);
  assign btb_we             = train_en && ex_taken;

  always_comb begin
    ctr_d = ctr_q;
    if (train_en && ex_is_cond) ctr_d = ctr_next(ctr_q, ex_taken);
    else                        ctr_d = ctr_q;
  end

  always_comb begin
    state_d  = state_q;
    next_pc  = current_pc;
    pc_write = 1'b0;
    flush    = 1'b0;
    if (!reset) begin
      next_pc = RESET_PC;
    end else begin
      case (state_q)
        INIT: begin
          next_pc  = RESET_PC;
          pc_write = 1'b1;
          state_d  = RUN;
        end
        RUN: begin
          if (halt) begin
            state_d = HALTED;
          end else if (mispredict) begin
            next_pc  = ex_actual_next_pc;
            pc_write = 1'b1;
            flush    = 1'b1;
          end else if (stall) begin
            pc_write = 1'b0;
          end else begin
            next_pc  = fetch_pred_next_pc;
            pc_write = 1'b1;
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = INIT;
          next_pc = RESET_PC;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      ctr_q   <= CTR_WEAK_NT;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a behavioural predictor model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] current_pc = 32'h0;
  logic        stall = 1'b0, halt = 1'b0;
  logic        ex_valid = 1'b0, ex_is_cond = 1'b0, ex_taken = 1'b0;
  logic [31:0] ex_pc = 32'h0, ex_actual_next_pc = 32'h0, ex_pred_next_pc = 32'h0;
  logic [31:0] next_pc, fetch_pred_next_pc;
  logic        pc_write, flush;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.BTB_ENTRIES(16), .RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .reset             (reset),
    .current_pc        (current_pc),
    .stall             (stall),
    .halt              (halt),
    .ex_valid          (ex_valid),
    .ex_is_cond        (ex_is_cond),
    .ex_pc             (ex_pc),
    .ex_taken          (ex_taken),
    .ex_actual_next_pc (ex_actual_next_pc),
    .ex_pred_next_pc   (ex_pred_next_pc),
    .next_pc           (next_pc),
    .pc_write          (pc_write),
    .fetch_pred_next_pc(fetch_pred_next_pc),
    .flush             (flush)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: table of taken branches and a counter 0..3.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr;
  bit          m_first, m_halted;
  int          wi;

  function automatic logic [31:0] model_pred(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) % 32'd16);
    if (m_valid[i] && (m_tag[i] == (pc >> 6)) && (m_ctr >= 2)) return m_tgt[i];
    return pc + 32'd4;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) m_valid[i] <= 1'b0;
      m_ctr    <= 1;
      m_first  <= 1'b1;
      m_halted <= 1'b0;
    end else if (!m_halted) begin
      if (!m_first && halt) m_halted <= 1'b1;
      m_first <= 1'b0;
      if (ex_valid && !halt) begin
        if (ex_is_cond)
          m_ctr <= ex_taken ? ((m_ctr == 3) ? 3 : m_ctr + 1) : ((m_ctr == 0) ? 0 : m_ctr - 1);
        if (ex_taken) begin
          wi = int'((ex_pc >> 2) % 32'd16);
          m_valid[wi] <= 1'b1;
          m_tag[wi]   <= ex_pc >> 6;
          m_tgt[wi]   <= ex_actual_next_pc;
        end
      end
    end
  end

  logic        e_pw, e_fl, np_care;
  logic [31:0] e_np;

  always @(negedge clk) begin
    np_care = 1'b1;
    e_np    = current_pc;
    if (!reset) begin
      e_pw = 1'b0; e_fl = 1'b0; e_np = RESET_PC;
    end else if (m_first) begin
      e_pw = 1'b1; e_fl = 1'b0; e_np = RESET_PC;
    end else if (m_halted) begin
      e_pw = 1'b0; e_fl = 1'b0; e_np = current_pc;
    end else if (halt) begin
      e_pw = 1'b0; e_fl = 1'b0; np_care = 1'b0;
    end else if (ex_valid && (ex_actual_next_pc != ex_pred_next_pc)) begin
      e_pw = 1'b1; e_fl = 1'b1; e_np = ex_actual_next_pc;
    end else if (stall) begin
      e_pw = 1'b0; e_fl = 1'b0; np_care = 1'b0;
    end else begin
      e_pw = 1'b1; e_fl = 1'b0; e_np = model_pred(current_pc);
    end
    chk("model_pc_write", {31'd0, pc_write}, {31'd0, e_pw});
    chk("model_flush", {31'd0, flush}, {31'd0, e_fl});
    if (np_care) chk("model_next_pc", next_pc, e_np);
    chk("model_fetch_pred", fetch_pred_next_pc, model_pred(current_pc));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_is_cond = 1'b0; ex_taken = 1'b0;
  endtask

  task automatic set_ex(input logic cond, input logic [31:0] pc, input logic tk,
                        input logic [31:0] act, input logic [31:0] pred);
    ex_valid = 1'b1; ex_is_cond = cond; ex_pc = pc; ex_taken = tk;
    ex_actual_next_pc = act; ex_pred_next_pc = pred;
  endtask

  initial begin
    // Reset held
    repeat (2) tick();
    #1;
    chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_next_pc", next_pc, 32'h0);
    chk("rst_pred", fetch_pred_next_pc, 32'h4);
    @(negedge clk); #2 reset = 1'b1;
    #1;
    chk("init_pc_write", {31'd0, pc_write}, 32'd1);
    chk("init_next_pc", next_pc, 32'h0);

    // Sequential fetch
    tick(); current_pc = 32'h0; #1 chk("seq_0", next_pc, 32'h4);
    tick(); current_pc = 32'h4; #1 chk("seq_4", next_pc, 32'h8);
    tick(); current_pc = 32'h8; #1 chk("seq_8", next_pc, 32'hC);
    chk("seq_flush", {31'd0, flush}, 32'd0);

    // Taken beq at 0x10 -> 0x40, predicted fall-through
    tick(); current_pc = 32'hC; set_ex(1'b1, 32'h10, 1'b1, 32'h40, 32'h14);
    #1;
    chk("mp_flush", {31'd0, flush}, 32'd1);
    chk("mp_next_pc", next_pc, 32'h40);
    tick(); idle_ex(); current_pc = 32'h40;
    tick(); current_pc = 32'h10; #1 chk("btb_hit_pred", fetch_pred_next_pc, 32'h40);
    tick(); current_pc = 32'h50; #1 chk("btb_tag_miss", fetch_pred_next_pc, 32'h54);

    // Not taken four times: counter 10->01->00->00
    tick(); current_pc = 32'h10; set_ex(1'b1, 32'h10, 1'b0, 32'h14, 32'h40);
    #1;
    chk("nt_same_cycle_old", fetch_pred_next_pc, 32'h40);
    chk("nt_mp_flush", {31'd0, flush}, 32'd1);
    tick(); set_ex(1'b1, 32'h10, 1'b0, 32'h14, 32'h14);
    #1;
    chk("nt_after_dec", fetch_pred_next_pc, 32'h14);
    chk("nt_no_flush", {31'd0, flush}, 32'd0);
    repeat (2) tick();
    tick(); set_ex(1'b1, 32'h10, 1'b1, 32'h40, 32'h14);
    #1 chk("ctr_sat_00", fetch_pred_next_pc, 32'h14);
    tick(); idle_ex();
    #1 chk("ctr_sat_01", fetch_pred_next_pc, 32'h14);

    // Stall for 3 cycles, then a redirect during the stall
    tick(); current_pc = 32'h20; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_hold", {31'd0, pc_write}, 32'd0);
      tick();
    end
    set_ex(1'b0, 32'h18, 1'b1, 32'h80, 32'h1C);
    #1;
    chk("stall_mp_write", {31'd0, pc_write}, 32'd1);
    chk("stall_mp_flush", {31'd0, flush}, 32'd1);
    chk("stall_mp_next", next_pc, 32'h80);

    // PC wrap
    tick(); idle_ex(); stall = 1'b0; current_pc = 32'hFFFF_FFFC;
    #1;
    chk("wrap_pred", fetch_pred_next_pc, 32'h0);
    chk("wrap_next", next_pc, 32'h0);

    // Halt together with a mispredict
    tick(); current_pc = 32'h24; halt = 1'b1; set_ex(1'b1, 32'h10, 1'b1, 32'h40, 32'h14);
    #1;
    chk("halt_write", {31'd0, pc_write}, 32'd0);
    chk("halt_flush", {31'd0, flush}, 32'd0);
    tick(); halt = 1'b0; idle_ex();
    for (int i = 0; i < 10; i++) begin
      #1 chk("halted_write", {31'd0, pc_write}, 32'd0);
      tick();
    end
    current_pc = 32'h10;
    #1;
    chk("halt_no_train", fetch_pred_next_pc, 32'h14);
    chk("halted_next", next_pc, 32'h10);

    // Reset out of HALTED, retrain, then reset mid-operation
    tick(); #2 reset = 1'b0;
    #1 chk("rst2_write", {31'd0, pc_write}, 32'd0);
    tick();
    @(negedge clk); #2 reset = 1'b1;
    #1 chk("init2_write", {31'd0, pc_write}, 32'd1);
    tick(); current_pc = 32'h10; set_ex(1'b1, 32'h10, 1'b1, 32'h40, 32'h14);
    #1 chk("retrain_flush", {31'd0, flush}, 32'd1);
    tick(); set_ex(1'b1, 32'h10, 1'b1, 32'h40, 32'h40);
    #1 chk("retrain_pred", fetch_pred_next_pc, 32'h40);
    tick(); idle_ex();
    #1 chk("retrain_strong", fetch_pred_next_pc, 32'h40);
    #1 reset = 1'b0;
    #1;
    chk("async_clear_pred", fetch_pred_next_pc, 32'h14);
    chk("async_clear_write", {31'd0, pc_write}, 32'd0);
    @(negedge clk); #2 reset = 1'b1;
    #1 chk("init3_next", next_pc, RESET_PC);
    tick(); current_pc = 32'h10;
    #1 chk("post_rst_pred", fetch_pred_next_pc, 32'h14);
    tick(); set_ex(1'b1, 32'h10, 1'b1, 32'h40, 32'h14);
    tick(); idle_ex();
    #1 chk("post_rst_ctr01", fetch_pred_next_pc, 32'h40);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
